// File: rtl/fifo_sync_param_if.sv
// Write/read handshake, fill status and error flags of fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  logic                         wr_en;
  logic [WIDTH-1:0]             wr_data;
  logic                         rd_en;
  logic [WIDTH-1:0]             rd_data;
  logic                         rd_valid;
  logic                         full;
  logic                         empty;
  logic                         almost_full;
  logic                         almost_empty;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         clr_err;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with optional first-word fall-through,
// fill level, almost-full/empty thresholds and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    r_ptr;
  logic [LW-1:0]    level_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  // Status decodes only the registered level, so no input reaches a flag combinationally.
  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= LW'(AFULL_LVL));
  assign bus.almost_empty = (level_q <= LW'(AEMPTY_LVL));
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[w_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= (w_ptr == PW'(DEPTH - 1)) ? '0 : w_ptr + 1'b1;
      if (rd_acc) r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A new error event takes priority over a coincident clear.
      if (bus.wr_en && full)      overflow_q <= 1'b1;
      else if (bus.clr_err)       overflow_q <= 1'b0;
      if (bus.rd_en && empty)     underflow_q <= 1'b1;
      else if (bus.clr_err)       underflow_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; zero while empty so reset shows rd_data=0.
    assign bus.rd_data  = empty ? '0 : mem[r_ptr];
    assign bus.rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[r_ptr];
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end
endmodule
